// File: rtl/brd_wb2ps_wc_tagram.sv
// brd_wb2ps_wc_tagram: 4-way x 16-line tag store with init sweep, lookup, fill and tree PLRU.
// Define WC_TAGRAM_DIRTY_EN for per-way dirty tracking and victim write-back reporting.
module brd_wb2ps_wc_tagram #(
  parameter int NWAY  = 4,
  parameter int TAG_W = 13
) (
  input  logic             cpuclk,
  input  logic             WSHRST_N,
  input  logic             taginit_en,
  input  logic [3:0]       taginit_lineno,
  input  logic             run_inittag,
  input  logic             lk_req,
  input  logic [16:0]      lk_adr,
  output logic             lk_ready,
  output logic             lk_ack,
  output logic             lk_hit,
  output logic [1:0]       lk_way,
  input  logic             fill_en,
  input  logic [1:0]       fill_way,
  input  logic [16:0]      fill_adr,
  output logic [TAG_W-1:0] lk_victim_tag,
  output logic             lk_victim_dirty,
  input  logic             lk_we
);
  logic             init_done;
  logic [TAG_W-1:0] tag_q [16][NWAY];
  logic [NWAY-1:0]  valid_q [16];
  logic [2:0]       plru_q [16];
  logic [3:0]       lk_line, fill_line;
  logic [NWAY-1:0]  match, vld;
  logic [2:0]       p;
  logic             accept, hit, fill_ok, touch_ok;
  logic [1:0]       hit_way, inv_way, vic_way;
  logic [TAG_W-1:0] vic_tag;
  logic             vic_dirty;

  function automatic logic [2:0] touch(input logic [2:0] pl, input logic [1:0] w);
    touch = w[1] ? {~w[0], pl[1], 1'b0} : {pl[2], ~w[0], 1'b1};
  endfunction

  assign lk_line   = lk_adr[3:0];
  assign fill_line = fill_adr[3:0];
  assign vld       = valid_q[lk_line];
  assign p         = plru_q[lk_line];
  assign lk_ready  = init_done & ~taginit_en & ~run_inittag;
  assign accept    = lk_req & lk_ready;

  for (genvar w = 0; w < NWAY; w++) begin : g_match
    assign match[w] = vld[w] & (tag_q[lk_line][w] == lk_adr[16:4]);
  end

  assign hit      = |match;
  assign hit_way  = match[0] ? 2'd0 : match[1] ? 2'd1 : match[2] ? 2'd2 : 2'd3;
  assign inv_way  = ~vld[0] ? 2'd0 : ~vld[1] ? 2'd1 : ~vld[2] ? 2'd2 : 2'd3;
  assign vic_way  = &vld ? {p[0], p[0] ? p[2] : p[1]} : inv_way;
  // a sweep beats a fill to the same line, and a fill beats the hit touch
  assign fill_ok  = fill_en & ~(taginit_en & (taginit_lineno == fill_line));
  assign touch_ok = accept & hit & ~(fill_en & (fill_line == lk_line));

  always_ff @(posedge cpuclk) begin
    if (touch_ok) plru_q[lk_line] <= touch(p, hit_way);
    if (fill_ok) begin
      tag_q[fill_line][fill_way]   <= fill_adr[16:4];
      valid_q[fill_line][fill_way] <= 1'b1;
      plru_q[fill_line]            <= touch(plru_q[fill_line], fill_way);
    end
    if (taginit_en) begin
      valid_q[taginit_lineno] <= '0;
      plru_q[taginit_lineno]  <= '0;
    end
  end

`ifdef WC_TAGRAM_DIRTY_EN
  logic [NWAY-1:0] dirty_q [16];
  always_ff @(posedge cpuclk) begin
    if (touch_ok & lk_we) dirty_q[lk_line][hit_way] <= 1'b1;
    if (fill_ok) dirty_q[fill_line][fill_way] <= 1'b0;
    if (taginit_en) dirty_q[taginit_lineno] <= '0;
  end
  assign vic_tag   = (~hit & vld[vic_way]) ? tag_q[lk_line][vic_way] : '0;
  assign vic_dirty = ~hit & vld[vic_way] & dirty_q[lk_line][vic_way];
`else
  logic unused_we;
  assign unused_we = lk_we;
  assign vic_tag   = '0;
  assign vic_dirty = 1'b0;
`endif

  always_ff @(posedge cpuclk) begin
    if (!WSHRST_N) begin
      lk_ack          <= 1'b0;
      lk_hit          <= 1'b0;
      lk_way          <= 2'd0;
      lk_victim_tag   <= '0;
      lk_victim_dirty <= 1'b0;
      init_done       <= 1'b0;
    end else begin
      lk_ack <= accept;
      if (accept) begin
        lk_hit          <= hit;
        lk_way          <= hit ? hit_way : vic_way;
        lk_victim_tag   <= vic_tag;
        lk_victim_dirty <= vic_dirty;
      end
      if (taginit_en && taginit_lineno == 4'hf) init_done <= 1'b1;
    end
  end

  a_onehot_match: assert property (@(posedge cpuclk) disable iff (!WSHRST_N) accept |-> $onehot0(match));
  a_fill_ready:   assert property (@(posedge cpuclk) disable iff (!WSHRST_N) (fill_en & ~taginit_en) |-> lk_ready);
endmodule
